// File: rtl/post_syn_pkg.sv
// Shared types and constants for the post-synaptic spike buffer.
// Bank lifecycle enum, default geometry, derived sizes and err bit positions.
package post_syn_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam int TIME_STEPS_DEF        = 3;
    localparam int OUT_CHANNELS_DEF      = 16;
    localparam int FRAME_WIDTH_DEF       = 6;
    localparam int PE_ARRAY_ROW_SIZE_DEF = 2;

    localparam int MAP_BITS = FRAME_WIDTH_DEF * FRAME_WIDTH_DEF;
    localparam int WORDS    = TIME_STEPS_DEF * OUT_CHANNELS_DEF;
    localparam int EVENTS   = WORDS / PE_ARRAY_ROW_SIZE_DEF;

    localparam int ERR_OVF    = 0;
    localparam int ERR_RANGE  = 1;
    localparam int ERR_INCOMP = 2;

    // Flattened word index: time step major, channel minor.
    function automatic int word_index(input int ts, input int oc, input int n_oc);
        return ts * n_oc + oc;
    endfunction

endpackage

// File: rtl/spk_bank_ram.sv
// One spike bank: PORTS parallel write ports and a single synchronous read port.
// Contents are not reset; the read register only updates on a read request.
module spk_bank_ram
    import post_syn_pkg::*;
#(
    parameter int MAP_W  = MAP_BITS,
    parameter int DEPTH  = WORDS,
    parameter int PORTS  = PE_ARRAY_ROW_SIZE_DEF,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic                              clk,
    input  logic [PORTS-1:0]                  we,
    input  logic [PORTS-1:0][ADDR_W-1:0]      waddr,
    input  logic [PORTS-1:0][MAP_W-1:0]       wdata,
    input  logic                              re,
    input  logic [ADDR_W-1:0]                 raddr,
    output logic [MAP_W-1:0]                  rdata
);

    logic [MAP_W-1:0] mem [DEPTH];

    // Write ports always target distinct words, so their order does not matter.
    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (we[p]) begin
                mem[waddr[p]] <= wdata[p];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/post_syn_spk_buffer.sv
// Ping-pong post-synaptic spike buffer between the dense neuron core and the next layer.
// Optional per-bank spike popcount enabled by defining SPK_BUFFER_POPCOUNT_EN.
module post_syn_spk_buffer
    import post_syn_pkg::*;
#(
    parameter int TIME_STEPS        = TIME_STEPS_DEF,
    parameter int OUT_CHANNELS      = OUT_CHANNELS_DEF,
    parameter int FRAME_WIDTH       = FRAME_WIDTH_DEF,
    parameter int PE_ARRAY_ROW_SIZE = PE_ARRAY_ROW_SIZE_DEF
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic [PE_ARRAY_ROW_SIZE-1:0][FRAME_WIDTH*FRAME_WIDTH-1:0] spk_arr,
    input  logic                                                     new_spk_train_ready,
    input  logic [$clog2(TIME_STEPS):0]                              prev_time_step,
    input  logic [$clog2(OUT_CHANNELS):0]                            prev_oc_phase,
    input  logic                                                     post_syn_RAM_loaded,
    output logic                                                     wr_ready,
    output logic                                                     out_RAM_loaded,
    input  logic                                                     rd_en,
    input  logic [$clog2(TIME_STEPS):0]                              rd_time_step,
    input  logic [$clog2(OUT_CHANNELS):0]                            rd_oc,
    output logic [FRAME_WIDTH*FRAME_WIDTH-1:0]                       rd_data,
    output logic                                                     rd_valid,
    input  logic                                                     rd_release,
    output logic [2:0]                                               err
`ifdef SPK_BUFFER_POPCOUNT_EN
    ,
    output logic [31:0]                                              spk_count
`endif
);

    localparam int MAP_W    = FRAME_WIDTH * FRAME_WIDTH;
    localparam int N_WORDS  = TIME_STEPS * OUT_CHANNELS;
    localparam int N_PHASES = OUT_CHANNELS / PE_ARRAY_ROW_SIZE;
    localparam int N_EVENTS = N_WORDS / PE_ARRAY_ROW_SIZE;
    localparam int ADDR_W   = $clog2(N_WORDS);
    localparam int CNT_W    = 16;

    bank_state_t                st_q [2];
    bank_state_t                st_d [2];
    logic                       wr_bank_q;
    logic                       rd_bank_q;
    logic                       wr_bank_d;
    logic                       rd_bank_d;
    logic                       loaded_q;
    logic                       loaded_d;
    logic [CNT_W-1:0]           evt_q [2];
    logic [CNT_W-1:0]           evt_final;
    logic [2:0]                 err_q;
    logic [2:0]                 err_d;

    logic                       wr_ok;
    logic                       wr_range_bad;
    logic                       do_write;
    logic                       do_close;
    logic                       do_rel;
    logic                       rd_ok;
    logic                       rd_oor;

    logic [PE_ARRAY_ROW_SIZE-1:0][ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0]          raddr;
    logic [MAP_W-1:0]           ram_q [2];

    logic                       vld_p1;
    logic                       has_p1;
    logic                       oor_p1;
    logic                       bank_p1;

    assign wr_ok        = (st_q[wr_bank_q] != FULL);
    assign wr_range_bad = (int'(prev_time_step) >= TIME_STEPS) ||
                          (int'(prev_oc_phase) >= N_PHASES);
    assign do_write     = new_spk_train_ready && wr_ok && !wr_range_bad;
    assign do_close     = post_syn_RAM_loaded && wr_ok;
    assign do_rel       = rd_release && loaded_q;
    assign rd_ok        = rd_en && loaded_q;
    assign rd_oor       = (int'(rd_time_step) >= TIME_STEPS) ||
                          (int'(rd_oc) >= OUT_CHANNELS);

    // A strobe coinciding with completion is part of the closing bank.
    assign evt_final    = evt_q[wr_bank_q] + CNT_W'(do_write);

    always_comb begin
        for (int r = 0; r < PE_ARRAY_ROW_SIZE; r++) begin
            waddr[r] = ADDR_W'(word_index(int'(prev_time_step), 
                                          int'(prev_oc_phase) * PE_ARRAY_ROW_SIZE + r,
                                          OUT_CHANNELS));
        end
        raddr = ADDR_W'(word_index(int'(rd_time_step), int'(rd_oc), OUT_CHANNELS));
    end

    // Bank lifecycle next state; close and release always hit different banks.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            st_d[b] = st_q[b];
            if (do_write && (wr_bank_q == 1'(b))) begin
                st_d[b] = FILLING;
            end
            if (do_close && (wr_bank_q == 1'(b))) begin
                st_d[b] = FULL;
            end
            if (do_rel && (rd_bank_q == 1'(b))) begin
                st_d[b] = EMPTY;
            end
        end
        wr_bank_d = wr_bank_q ^ do_close;
        rd_bank_d = rd_bank_q ^ do_rel;
        loaded_d  = (st_d[rd_bank_d] == FULL);
    end

    always_comb begin
        err_d = err_q;
        if (new_spk_train_ready && wr_range_bad) begin
            err_d[ERR_RANGE] = 1'b1;
        end
        if ((new_spk_train_ready || post_syn_RAM_loaded) && !wr_ok) begin
            err_d[ERR_OVF] = 1'b1;
        end
        if (do_close && (evt_final != CNT_W'(N_EVENTS))) begin
            err_d[ERR_INCOMP] = 1'b1;
        end
        if (rd_ok && rd_oor) begin
            err_d[ERR_RANGE] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q[0]   <= EMPTY;
            st_q[1]   <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            loaded_q  <= 1'b0;
            evt_q[0]  <= '0;
            evt_q[1]  <= '0;
            err_q     <= '0;
        end else begin
            st_q[0]   <= st_d[0];
            st_q[1]   <= st_d[1];
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
            for (int b = 0; b < 2; b++) begin
                if (do_close && (wr_bank_q == 1'(b))) begin
                    evt_q[b] <= '0;
                end else if (do_write && (wr_bank_q == 1'(b)) && (evt_q[b] != '1)) begin
                    evt_q[b] <= evt_q[b] + 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        spk_bank_ram #(
            .MAP_W  (MAP_W),
            .DEPTH  (N_WORDS),
            .PORTS  (PE_ARRAY_ROW_SIZE),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    ({PE_ARRAY_ROW_SIZE{do_write && (wr_bank_q == 1'(b))}}),
            .waddr (waddr),
            .wdata (spk_arr),
            .re    (rd_ok && !rd_oor && (rd_bank_q == 1'(b))),
            .raddr (raddr),
            .rdata (ram_q[b])
        );
    end

    // p0 -> p1: read request accepted, RAM word arrives next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            has_p1  <= 1'b0;
            oor_p1  <= 1'b0;
            bank_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_ok;
            if (rd_ok) begin
                has_p1  <= 1'b1;
                oor_p1  <= rd_oor;
                bank_p1 <= rd_bank_q;
            end
        end
    end

    assign rd_data        = (has_p1 && !oor_p1) ? ram_q[bank_p1] : '0;
    assign rd_valid       = vld_p1;
    assign wr_ready       = wr_ok;
    assign out_RAM_loaded = loaded_q;
    assign err            = err_q;

`ifdef SPK_BUFFER_POPCOUNT_EN
    logic [31:0] pop_sum;
    logic [31:0] spk_q [2];

    always_comb begin
        pop_sum = '0;
        for (int r = 0; r < PE_ARRAY_ROW_SIZE; r++) begin
            for (int i = 0; i < MAP_W; i++) begin
                pop_sum = pop_sum + 32'(spk_arr[r][i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spk_q[0] <= '0;
            spk_q[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (do_rel && (rd_bank_q == 1'(b))) begin
                    spk_q[b] <= '0;
                end else if (do_write && (wr_bank_q == 1'(b))) begin
                    spk_q[b] <= spk_q[b] + pop_sum;
                end
            end
        end
    end

    assign spk_count = loaded_q ? spk_q[rd_bank_q] : '0;
`endif

endmodule

// File: tb/tb_post_syn_spk_buffer.sv
// Bench for post_syn_spk_buffer: directed scenarios with random spike maps,
// checked every cycle against a FIFO-of-inferences reference model.
module tb_post_syn_spk_buffer;
    import post_syn_pkg::*;

    localparam int TS = 3;
    localparam int OC = 16;
    localparam int PR = 2;
    localparam int MB = MAP_BITS;
    localparam int NW = WORDS;
    localparam int NE = EVENTS;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [PR-1:0][MB-1:0] spk_arr = '0;
    logic               new_spk_train_ready = 1'b0;
    logic [2:0]         prev_time_step = '0;
    logic [4:0]         prev_oc_phase = '0;
    logic               post_syn_RAM_loaded = 1'b0;
    logic               wr_ready;
    logic               out_RAM_loaded;
    logic               rd_en = 1'b0;
    logic [2:0]         rd_time_step = '0;
    logic [4:0]         rd_oc = '0;
    logic [MB-1:0]      rd_data;
    logic               rd_valid;
    logic               rd_release = 1'b0;
    logic [2:0]         err;
`ifdef SPK_BUFFER_POPCOUNT_EN
    logic [31:0]        spk_count;
`endif

    post_syn_spk_buffer #(
        .TIME_STEPS        (TS),
        .OUT_CHANNELS      (OC),
        .FRAME_WIDTH       (6),
        .PE_ARRAY_ROW_SIZE (PR)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .spk_arr             (spk_arr),
        .new_spk_train_ready (new_spk_train_ready),
        .prev_time_step      (prev_time_step),
        .prev_oc_phase       (prev_oc_phase),
        .post_syn_RAM_loaded (post_syn_RAM_loaded),
        .wr_ready            (wr_ready),
        .out_RAM_loaded      (out_RAM_loaded),
        .rd_en               (rd_en),
        .rd_time_step        (rd_time_step),
        .rd_oc               (rd_oc),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .rd_release          (rd_release),
        .err                 (err)
`ifdef SPK_BUFFER_POPCOUNT_EN
        ,
        .spk_count           (spk_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: completed inferences queue up (at most two held), reads
    // come from the oldest one, release retires it.
    logic [MB-1:0] store [8][NW];
    int            full_q[$];
    int            cur_inf = 0;
    int            cur_events = 0;
    logic [2:0]    m_err = '0;
    logic [MB-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    int unsigned   m_pop [8];

    int checks = 0;
    int errors = 0;

    function automatic int unsigned popc(input logic [MB-1:0] v);
        int unsigned n = 0;
        for (int i = 0; i < MB; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  pre = full_q.size();
        bit  ok = (pre < 2);
        bit  loaded = (pre > 0);
        bit  bad;
        m_valid = 1'b0;
        if (rd_en && loaded) begin
            m_valid = 1'b1;
            if (int'(rd_time_step) >= TS || int'(rd_oc) >= OC) begin
                m_data = '0;
                m_err[1] = 1'b1;
            end else begin
                m_data = store[full_q[0] % 8][int'(rd_time_step) * OC + int'(rd_oc)];
            end
        end
        if (new_spk_train_ready) begin
            bad = (int'(prev_time_step) >= TS) || (int'(prev_oc_phase) >= OC / PR);
            if (bad) m_err[1] = 1'b1;
            if (!ok) m_err[0] = 1'b1;
            else if (!bad) begin
                for (int r = 0; r < PR; r++) begin
                    store[cur_inf % 8][int'(prev_time_step) * OC + int'(prev_oc_phase) * PR + r] = spk_arr[r];
                    m_pop[cur_inf % 8] += popc(spk_arr[r]);
                end
                cur_events++;
            end
        end
        if (post_syn_RAM_loaded) begin
            if (!ok) m_err[0] = 1'b1;
            else begin
                if (cur_events != NE) m_err[2] = 1'b1;
                full_q.push_back(cur_inf);
                cur_inf++;
                cur_events = 0;
                m_pop[cur_inf % 8] = 0;
            end
        end
        if (rd_release && loaded) void'(full_q.pop_front());
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wr_ready"}, 64'(wr_ready), 64'(full_q.size() < 2));
        chk({tag, ".loaded"}, 64'(out_RAM_loaded), 64'(full_q.size() > 0));
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_valid));
        chk({tag, ".rd_data"}, 64'(rd_data), 64'(m_data));
        chk({tag, ".err"}, 64'(err), 64'(m_err));
`ifdef SPK_BUFFER_POPCOUNT_EN
        chk({tag, ".spk_count"}, 64'(spk_count),
            64'((full_q.size() > 0) ? m_pop[full_q[0] % 8] : 0));
`endif
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        new_spk_train_ready = 1'b0;
        post_syn_RAM_loaded = 1'b0;
        rd_en = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic set_strobe(input int t, input int ph, input bit ones);
        new_spk_train_ready = 1'b1;
        prev_time_step = 3'(t);
        prev_oc_phase = 5'(ph);
        for (int r = 0; r < PR; r++)
            spk_arr[r] = ones ? '1 : MB'({$urandom(), $urandom()});
    endtask

    task automatic fill(input int n, input bit ones);
        for (int k = 0; k < n; k++) begin
            set_strobe(k / 8, k % 8, ones);
            cycle("fill");
        end
    endtask

    task automatic rd(input int t, input int o, input string tag);
        rd_en = 1'b1;
        rd_time_step = 3'(t);
        rd_oc = 5'(o);
        cycle(tag);
    endtask

    task automatic do_reset(input string tag);
        #3 rst = 1'b0;
        #1;
        chk({tag, ".async_wr_ready"}, 64'(wr_ready), 64'd1);
        chk({tag, ".async_loaded"}, 64'(out_RAM_loaded), 64'd0);
        chk({tag, ".async_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, ".async_err"}, 64'(err), 64'd0);
        chk({tag, ".async_rd_data"}, 64'(rd_data), 64'd0);
        full_q.delete();
        cur_events = 0;
        m_err = '0;
        m_data = '0;
        m_valid = 1'b0;
        cur_inf++;
        m_pop[cur_inf % 8] = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        cycle({tag, ".idle"});
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_pop[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("por.wr_ready", 64'(wr_ready), 64'd1);
        chk("por.loaded", 64'(out_RAM_loaded), 64'd0);
        chk("por.rd_valid", 64'(rd_valid), 64'd0);
        chk("por.rd_data", 64'(rd_data), 64'd0);
        chk("por.err", 64'(err), 64'd0);
        rst = 1'b1;
        cycle("idle");

        // Full fill, completion, targeted and random reads
        fill(NE, 1'b0);
        post_syn_RAM_loaded = 1'b1;
        cycle("close1");
        chk("close1.loaded_now", 64'(out_RAM_loaded), 64'd1);
        rd(1, 5, "rd_t1_oc5");
        chk("rd_t1_oc5.phase2_row1", 64'(rd_data), 64'(store[full_q[0] % 8][1 * OC + 2 * PR + 1]));
        cycle("hold");
        for (int i = 0; i < 4; i++) rd($urandom_range(0, TS - 1), $urandom_range(0, OC - 1), "rd_rand1");

        // Ping-pong: second bank fills without release
        fill(NE, 1'b0);
        post_syn_RAM_loaded = 1'b1;
        cycle("close2");
        chk("close2.wr_ready_low", 64'(wr_ready), 64'd0);
        set_strobe(0, 0, 1'b0);
        cycle("ovf_strobe");
        post_syn_RAM_loaded = 1'b1;
        rd_release = 1'b1;
        cycle("close_rel_same");
        chk("rel.wr_ready_high", 64'(wr_ready), 64'd1);
        for (int i = 0; i < 4; i++) rd($urandom_range(0, TS - 1), $urandom_range(0, OC - 1), "rd_bank1");
        rd_release = 1'b1;
        cycle("rel2");
        do_reset("rst1");

        // Incomplete inference
        fill(NE - 1, 1'b0);
        post_syn_RAM_loaded = 1'b1;
        cycle("close_incomplete");
        rd(0, 0, "rd_incomplete");
        rd(2, 13, "rd_incomplete2");
        do_reset("rst2");

        // Range errors on write and read
        fill(NE, 1'b0);
        set_strobe(0, 8, 1'b0);
        cycle("range_phase8");
        set_strobe(3, 0, 1'b0);
        cycle("range_ts3");
        post_syn_RAM_loaded = 1'b1;
        cycle("close_range");
        rd(1, 0, "rd_alias_intact");
        rd(0, 16, "rd_oc16");
        rd(3, 0, "rd_ts3");
        cycle("hold_oor");
        do_reset("rst3");

        // Final strobe coincides with completion
        fill(NE - 1, 1'b0);
        set_strobe(2, 7, 1'b0);
        post_syn_RAM_loaded = 1'b1;
        cycle("close_simul");
        rd(2, 15, "rd_simul15");
        rd(2, 14, "rd_simul14");

        // Reset mid-read, then mid-fill
        rd(1, 3, "rd_before_rst");
        do_reset("rst_midread");
        fill(10, 1'b0);
        do_reset("rst_midfill");

        // All-ones maps
        fill(NE, 1'b1);
        post_syn_RAM_loaded = 1'b1;
        cycle("close_ones");
`ifdef SPK_BUFFER_POPCOUNT_EN
        chk("spk_count_1728", 64'(spk_count), 64'd1728);
`endif
        rd(0, 0, "rd_ones");
        rd_release = 1'b1;
        cycle("rel_ones");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/post_syn_spk_buffer.md
Name: post_syn_spk_buffer

Overview:
- Downstream consumer of the dense neuron core's spike output.
- Captures every PE-row spike map (one FRAME_WIDTH² bit-vector per output channel per time step) into a ping-pong pair of post-synaptic spike banks.
- Presents a completed bank to the next layer through a loaded/release handshake, so the core can fill one bank while the next layer drains the other.

Parameters:
- TIME_STEPS, 3, time steps per inference.
- OUT_CHANNELS, 16, output channels of the producing core.
- FRAME_WIDTH, 6, spike map is FRAME_WIDTH×FRAME_WIDTH bits.
- PE_ARRAY_ROW_SIZE, 2, spike maps delivered per write event (one per PE row).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- spk_arr  in  [PE_ARRAY_ROW_SIZE][FRAME_WIDTH²]  spike maps, row r = channel oc_phase*PE_ARRAY_ROW_SIZE+r.
- new_spk_train_ready  in  1  write strobe; spk_arr and indices are valid this cycle.
- prev_time_step  in  $clog2(TIME_STEPS)+1  time step of the strobed maps.
- prev_oc_phase  in  $clog2(OUT_CHANNELS)+1  oc phase of the strobed maps.
- post_syn_RAM_loaded  in  1  pulse: producer finished the whole inference.
- wr_ready  out  1  a write bank is free.
- out_RAM_loaded  out  1  read bank holds a complete inference (level).
- rd_en  in  1  read request.
- rd_time_step  in  $clog2(TIME_STEPS)+1  read address: time step.
- rd_oc  in  $clog2(OUT_CHANNELS)+1  read address: channel.
- rd_data  out  FRAME_WIDTH²  spike map.
- rd_valid  out  1  rd_data valid.
- rd_release  in  1  pulse: consumer finished the read bank.
- err  out  3  sticky: {incomplete, range, overflow}.

Behaviour:
- Storage: 2 banks × TIME_STEPS × OUT_CHANNELS words of FRAME_WIDTH² bits. Memory is not reset.
- Bank states: EMPTY → FILLING → FULL → EMPTY.
- Pointers wr_bank and rd_bank are 1 bit each, reset to 0. Both banks reset EMPTY.
- wr_ready = 1 when the wr_bank state is EMPTY or FILLING.
- Write path, when new_spk_train_ready=1 and wr_ready=1:
  - For each r, store spk_arr[r] at [wr_bank][prev_time_step][prev_oc_phase*PE_ARRAY_ROW_SIZE+r].
  - The write bank moves EMPTY→FILLING.
  - A per-bank write-event counter increments.
  - Writes take effect at the same clock edge.
- Range check: prev_time_step≥TIME_STEPS or prev_oc_phase≥OUT_CHANNELS/PE_ARRAY_ROW_SIZE → write dropped, err[1] set.
- Overflow: strobe while wr_ready=0 → write dropped, err[0] set.
- Completion, on post_syn_RAM_loaded:
  - The write bank goes to FULL and wr_bank toggles.
  - If the write-event counter ≠ TIME_STEPS*OUT_CHANNELS/PE_ARRAY_ROW_SIZE, err[2] is set; the bank still goes FULL.
  - The counter clears.
  - A strobe in the same cycle is written before the bank closes and is counted.
  - post_syn_RAM_loaded while wr_ready=0 → ignored, err[0] set.
- out_RAM_loaded = (rd_bank state == FULL), registered.
- Read path:
  - rd_en while out_RAM_loaded=1 → rd_data and rd_valid=1 on the next cycle (1-cycle latency). Otherwise rd_valid=0 next cycle and rd_data holds.
  - Out-of-range read address → rd_data=0, err[1] set.
- Release: rd_release while out_RAM_loaded=1 → bank EMPTY, rd_bank toggles, out_RAM_loaded deasserts next cycle.
  - rd_release while out_RAM_loaded=0 → ignored.
  - rd_en and rd_release in the same cycle: the read completes from the old bank.
- Release and completion in the same cycle, both banks busy: the release frees a bank, but wr_ready is evaluated on pre-edge state, so the completion is ignored and err[0] is set. Required behaviour; the producer must not do this.
- err clears only on reset.
- Reset values: wr_ready=1, out_RAM_loaded=0, rd_valid=0, rd_data=0, err=0.
- Reset mid-operation: banks EMPTY, counters 0, all in-flight data discarded.

Optional Feature:
- Macro: SPK_BUFFER_POPCOUNT_EN.
- Defined:
  - Per-bank 32-bit spike counter; each write adds the popcount of all PE_ARRAY_ROW_SIZE maps (combinational adder tree, registered).
  - The counter clears when its bank goes EMPTY.
  - Extra output spk_count [31:0] shows the rd_bank count, valid while out_RAM_loaded=1, else 0.
- Not defined: spk_count port and counters absent; all other behaviour identical.

Decomposition:
- Package post_syn_pkg holds:
  - bank_state_t enum {EMPTY, FILLING, FULL}.
  - Localparams: MAP_BITS=FRAME_WIDTH², WORDS=TIME_STEPS*OUT_CHANNELS, EVENTS=WORDS/PE_ARRAY_ROW_SIZE.
  - err bit index constants.
- Sub-module spk_bank_ram:
  - One bank.
  - PE_ARRAY_ROW_SIZE parallel write ports.
  - One synchronous read port.
  - Instantiated twice.

Test Plan:
- Full fill: 24 strobes (t=0..2, phase=0..7), distinct maps, then post_syn_RAM_loaded.
  - out_RAM_loaded=1 next cycle; err=0.
  - Read t=1, oc=5 → map written at phase 2 row 1, one cycle after rd_en.
- Ping-pong:
  - Fill bank0, then fill bank1 without a release → wr_ready=0 after the second completion.
  - A third strobe → dropped, err[0]=1.
  - rd_release → wr_ready=1, reads now return bank1 data.
- Incomplete: 23 strobes then completion → err[2]=1; the bank is still readable.
- Range: strobe with prev_oc_phase=8 → nothing written, err[1]=1. Read rd_oc=16 → rd_data=0.
- Simultaneous: final strobe and post_syn_RAM_loaded in the same cycle → that word is stored, err[2]=0.
- Reset: assert rst low mid-fill and mid-read → wr_ready=1, out_RAM_loaded=0, rd_valid=0, err=0 asynchronously. With SPK_BUFFER_POPCOUNT_EN, all-ones maps give spk_count=24*2*36=1728.
